// File: rtl/ether_dma_queues_p_pkg.sv
// Shared constants for the Ethernet DMA queue bank: CPU read offsets, status bit
// positions and RX completion field layout.
package ether_dma_queues_p_pkg;

  // CPU read selectors, decoded from aq[5:3]
  localparam logic [2:0] RD_CMPL   = 3'd0;
  localparam logic [2:0] RD_STATUS = 3'd1;
  localparam logic [2:0] RD_OCC    = 3'd2;
  localparam logic [2:0] RD_GOOD   = 3'd3;
  localparam logic [2:0] RD_BAD    = 3'd4;

  localparam int unsigned ST_HDR_AVAIL  = 0;
  localparam int unsigned ST_TX_AF      = 1;
  localparam int unsigned ST_CMPL_EMPTY = 2;
  localparam int unsigned ST_OFLOW      = 3;
  localparam int unsigned ST_UFLOW      = 4;

  localparam int unsigned OCC_RX_LSB = 0;
  localparam int unsigned OCC_TX_LSB = 16;

  // RX completion word: {len[10:0], goodFrame, badFrame}
  localparam int unsigned CMPL_BAD_BIT  = 0;
  localparam int unsigned CMPL_GOOD_BIT = 1;
  localparam int unsigned CMPL_LEN_LSB  = 2;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/ether_dma_queues_p_if.sv
// CPU ring and Ether DMA engine signals of the queue bank; slave is the queue bank's view.
interface ether_dma_queues_p_if #(
  parameter int unsigned ADDR_W = 28,
  parameter int unsigned LEN_W  = 27,
  parameter int unsigned CMPL_W = 13,
  parameter int unsigned RQ_W   = 32
);
  logic [30:3]       aq;
  logic              read;
  logic [ADDR_W-1:0] wq;
  logic              selEQ;
  logic              rwq;
  logic              wrq;
  logic              done;
  logic [RQ_W-1:0]   rqEQ;
  logic              RXheaderCountNonzero;
  logic [ADDR_W-1:0] RXdmaAddr;
  logic              RXdmaEmpty;
  logic              readRXdmaAddr;
  logic [CMPL_W-1:0] RXframeLength;
  logic              writeFrameLength;
  logic [ADDR_W-1:0] TXdmaAddr;
  logic              TXdmaEmpty;
  logic              readTXdmaAddr;
  logic [LEN_W-1:0]  TXdmaLength;
  logic              readTXdmaLength;
  logic              headerRead;

  modport slave (
    input  aq, read, wq, selEQ, RXheaderCountNonzero, readRXdmaAddr, RXframeLength,
           writeFrameLength, readTXdmaAddr, readTXdmaLength,
    output rwq, wrq, done, rqEQ, RXdmaAddr, RXdmaEmpty, TXdmaAddr, TXdmaEmpty, TXdmaLength,
           headerRead
  );

  modport master (
    output aq, read, wq, selEQ, RXheaderCountNonzero, readRXdmaAddr, RXframeLength,
           writeFrameLength, readTXdmaAddr, readTXdmaLength,
    input  rwq, wrq, done, rqEQ, RXdmaAddr, RXdmaEmpty, TXdmaAddr, TXdmaEmpty, TXdmaLength,
           headerRead
  );
endinterface

// File: rtl/ether_dma_queues_p_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count, almost-full level and
// single-cycle overflow/underflow strobes. Pushing a full FIFO is allowed when it also pops.
module ether_dma_queues_p_fifo #(
  parameter int unsigned W          = 8,
  parameter int unsigned DEPTH_LOG2 = 6,
  parameter int unsigned AF_MARGIN  = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                push,
  input  logic [W-1:0]        din,
  input  logic                pop,
  output logic [W-1:0]        dout,
  output logic [DEPTH_LOG2:0] count,
  output logic                full,
  output logic                empty,
  output logic                almost_full,
  output logic                overflow,
  output logic                underflow
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;
  localparam logic [DEPTH_LOG2:0] DepthC = CW'(Depth);
  localparam logic [DEPTH_LOG2:0] AfC    = CW'(Depth - AF_MARGIN);

  logic [W-1:0]          mem_q [Depth];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  wr_en, rd_en;

  assign full        = (count_q == DepthC);
  assign empty       = (count_q == '0);
  assign almost_full = (count_q >= AfC);
  assign count       = count_q;
  assign dout        = mem_q[rd_ptr_q];

  assign wr_en     = push & (~full | pop);
  assign rd_en     = pop & ~empty;
  assign overflow  = push & full & ~pop;
  assign underflow = pop & empty;

  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + DEPTH_LOG2'(1) : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + DEPTH_LOG2'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; pointers define what is valid.
  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/ether_dma_queues_p.sv
// Ethernet DMA queue bank (ring I/O device 1): TX addr/len, RX addr and RX completion queues.
// Define ETHQ_STATS_EN to add saturating good/bad frame counters readable at offsets 3/4.
module ether_dma_queues_p
  import ether_dma_queues_p_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = 6,
  parameter int unsigned AF_MARGIN  = 16,
  parameter int unsigned ADDR_W     = 28,
  parameter int unsigned LEN_W      = 27,
  parameter int unsigned CMPL_W     = 13,
  parameter int unsigned RQ_W       = 32
) (
  input logic                 clock,
  input logic                 reset,
  ether_dma_queues_p_if.slave bus
);

  localparam int unsigned CW = DEPTH_LOG2 + 1;

  logic cpu_wr, cpu_rd, tx_push, rx_push, flag_clr, cmpl_pop;
  logic [DEPTH_LOG2:0] tx_count, txl_count, rx_count, cmpl_count;
  logic tx_full, tx_af, tx_ov, tx_uf;
  logic txl_full, txl_empty, txl_af, txl_ov, txl_uf;
  logic rx_full, rx_af, rx_ov, rx_uf;
  logic cmpl_full, cmpl_empty, cmpl_af, cmpl_ov, cmpl_uf;
  logic [CMPL_W-1:0] cmpl_dout;
  logic oflow_q, oflow_d, uflow_q, uflow_d, header_q, header_d;
  logic [RQ_W-1:0] rq;

  assign cpu_wr   = bus.selEQ & ~bus.read;
  assign cpu_rd   = bus.selEQ & bus.read;
  assign tx_push  = cpu_wr & ~bus.aq[3];
  assign rx_push  = cpu_wr & bus.aq[3] & ~bus.aq[4];
  assign flag_clr = cpu_wr & bus.aq[3] & bus.aq[4];
  // An empty completion queue reads as 0 without popping or flagging underflow.
  assign cmpl_pop = cpu_rd & (bus.aq[5:3] == RD_CMPL) & ~cmpl_empty;

  assign bus.done = bus.selEQ;
  assign bus.wrq  = cpu_rd;
  assign bus.rwq  = cpu_wr;

  ether_dma_queues_p_fifo #(.W(ADDR_W), .DEPTH_LOG2(DEPTH_LOG2), .AF_MARGIN(AF_MARGIN)) u_tx_addr (
    .clock(clock), .reset(reset), .push(tx_push), .din(bus.wq), .pop(bus.readTXdmaAddr),
    .dout(bus.TXdmaAddr), .count(tx_count), .full(tx_full), .empty(bus.TXdmaEmpty),
    .almost_full(tx_af), .overflow(tx_ov), .underflow(tx_uf)
  );

  ether_dma_queues_p_fifo #(.W(LEN_W), .DEPTH_LOG2(DEPTH_LOG2), .AF_MARGIN(AF_MARGIN)) u_tx_len (
    .clock(clock), .reset(reset), .push(tx_push), .din(LEN_W'(bus.aq[30:4])),
    .pop(bus.readTXdmaLength), .dout(bus.TXdmaLength), .count(txl_count), .full(txl_full),
    .empty(txl_empty), .almost_full(txl_af), .overflow(txl_ov), .underflow(txl_uf)
  );

  ether_dma_queues_p_fifo #(.W(ADDR_W), .DEPTH_LOG2(DEPTH_LOG2), .AF_MARGIN(AF_MARGIN)) u_rx_addr (
    .clock(clock), .reset(reset), .push(rx_push), .din(bus.wq), .pop(bus.readRXdmaAddr),
    .dout(bus.RXdmaAddr), .count(rx_count), .full(rx_full), .empty(bus.RXdmaEmpty),
    .almost_full(rx_af), .overflow(rx_ov), .underflow(rx_uf)
  );

  ether_dma_queues_p_fifo #(.W(CMPL_W), .DEPTH_LOG2(DEPTH_LOG2), .AF_MARGIN(AF_MARGIN)) u_cmpl (
    .clock(clock), .reset(reset), .push(bus.writeFrameLength), .din(bus.RXframeLength),
    .pop(cmpl_pop), .dout(cmpl_dout), .count(cmpl_count), .full(cmpl_full), .empty(cmpl_empty),
    .almost_full(cmpl_af), .overflow(cmpl_ov), .underflow(cmpl_uf)
  );

  logic unused_fifo;
  assign unused_fifo = ^{tx_full, txl_count, txl_full, txl_empty, txl_af, rx_full, cmpl_count,
                         cmpl_full, cmpl_af};

  // A clear and a new event in the same cycle leaves the flag set.
  always_comb begin
    oflow_d  = (oflow_q & ~flag_clr) | tx_ov | txl_ov | rx_ov | cmpl_ov;
    uflow_d  = (uflow_q & ~flag_clr) | tx_uf | txl_uf | rx_uf | cmpl_uf;
    header_d = header_q ^ rx_push;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      oflow_q  <= 1'b0;
      uflow_q  <= 1'b0;
      header_q <= 1'b0;
    end else begin
      oflow_q  <= oflow_d;
      uflow_q  <= uflow_d;
      header_q <= header_d;
    end
  end

  assign bus.headerRead = header_q;

`ifdef ETHQ_STATS_EN
  logic [31:0] good_q, good_d, bad_q, bad_d;

  always_comb begin
    good_d = flag_clr ? '0 : good_q;
    bad_d  = flag_clr ? '0 : bad_q;
    if (bus.writeFrameLength && bus.RXframeLength[CMPL_GOOD_BIT]) good_d = sat_inc(good_d);
    if (bus.writeFrameLength && bus.RXframeLength[CMPL_BAD_BIT])  bad_d  = sat_inc(bad_d);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      good_q <= '0;
      bad_q  <= '0;
    end else begin
      good_q <= good_d;
      bad_q  <= bad_d;
    end
  end
`endif

  always_comb begin
    rq = '0;
    case (bus.aq[5:3])
      RD_CMPL: begin
        if (!cmpl_empty) rq = RQ_W'(cmpl_dout);
      end
      RD_STATUS: begin
        // Hide headers the CPU could not post a receive buffer for.
        rq[ST_HDR_AVAIL]  = bus.RXheaderCountNonzero & ~rx_af;
        rq[ST_TX_AF]      = tx_af;
        rq[ST_CMPL_EMPTY] = cmpl_empty;
        rq[ST_OFLOW]      = oflow_q;
        rq[ST_UFLOW]      = uflow_q;
      end
      RD_OCC: begin
        rq[OCC_TX_LSB +: CW] = tx_count;
        rq[OCC_RX_LSB +: CW] = rx_count;
      end
`ifdef ETHQ_STATS_EN
      RD_GOOD: rq = RQ_W'(good_q);
      RD_BAD:  rq = RQ_W'(bad_q);
`endif
      default: rq = '0;
    endcase
  end

  assign bus.rqEQ = rq;

endmodule

// File: tb/tb_ether_dma_queues_p.sv
// Self-checking bench for ether_dma_queues_p: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_ether_dma_queues_p;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #4 clock = ~clock;

  ether_dma_queues_p_if bus ();
  ether_dma_queues_p dut (.clock(clock), .reset(reset), .bus(bus));

`ifdef ETHQ_STATS_EN
  localparam bit StatsEn = 1'b1;
`else
  localparam bit StatsEn = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model
  bit [27:0] m_txa[$];
  bit [26:0] m_txl[$];
  bit [27:0] m_rxa[$];
  bit [12:0] m_cm[$];
  bit m_oflow, m_uflow, m_hdr;
  int unsigned m_good, m_bad;

  function automatic logic [31:0] exp_rq(input logic [2:0] sel, input logic hnz);
    case (sel)
      3'd0: return (m_cm.size() > 0) ? 32'(m_cm[0]) : 32'd0;
      3'd1: return {27'd0, m_uflow, m_oflow, (m_cm.size() == 0), (m_txa.size() >= 48),
                    (hnz && (m_rxa.size() < 48))};
      3'd2: return (32'(m_txa.size()) << 16) | 32'(m_rxa.size());
      3'd3: return StatsEn ? 32'(m_good) : 32'd0;
      3'd4: return StatsEn ? 32'(m_bad) : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step;
    bit txp, rxp, clr, cmpop, oe, ue;
    if (reset) begin
      m_txa.delete(); m_txl.delete(); m_rxa.delete(); m_cm.delete();
      m_oflow = 0; m_uflow = 0; m_hdr = 0; m_good = 0; m_bad = 0;
      return;
    end
    txp = 0; rxp = 0; clr = 0; cmpop = 0; oe = 0; ue = 0;
    if (bus.selEQ && !bus.read) begin
      if (!bus.aq[3]) txp = 1;
      else if (!bus.aq[4]) rxp = 1;
      else clr = 1;
    end
    if (bus.selEQ && bus.read && bus.aq[5:3] == 3'd0 && m_cm.size() > 0) cmpop = 1;
    if (bus.readTXdmaAddr) begin
      if (m_txa.size() == 0) ue = 1; else void'(m_txa.pop_front());
    end
    if (bus.readTXdmaLength) begin
      if (m_txl.size() == 0) ue = 1; else void'(m_txl.pop_front());
    end
    if (bus.readRXdmaAddr) begin
      if (m_rxa.size() == 0) ue = 1; else void'(m_rxa.pop_front());
    end
    if (cmpop) void'(m_cm.pop_front());
    if (txp) begin
      if (m_txa.size() < 64) m_txa.push_back(bus.wq); else oe = 1;
      if (m_txl.size() < 64) m_txl.push_back(bus.aq[30:4]); else oe = 1;
    end
    if (rxp) begin
      if (m_rxa.size() < 64) m_rxa.push_back(bus.wq); else oe = 1;
      m_hdr = ~m_hdr;
    end
    if (clr) begin m_good = 0; m_bad = 0; end
    if (bus.writeFrameLength) begin
      if (m_cm.size() < 64) m_cm.push_back(bus.RXframeLength); else oe = 1;
      if (bus.RXframeLength[1] && m_good != 32'hFFFF_FFFF) m_good++;
      if (bus.RXframeLength[0] && m_bad != 32'hFFFF_FFFF) m_bad++;
    end
    m_oflow = (m_oflow && !clr) || oe;
    m_uflow = (m_uflow && !clr) || ue;
  endtask

  task automatic step;
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_idle;
    bus.selEQ = 0; bus.read = 0; bus.aq = '0; bus.wq = '0;
    bus.readRXdmaAddr = 0; bus.readTXdmaAddr = 0; bus.readTXdmaLength = 0;
    bus.writeFrameLength = 0; bus.RXframeLength = '0;
  endtask

  task automatic cpu_read(input logic [2:0] sel);
    drive_idle();
    bus.selEQ = 1; bus.read = 1; bus.aq = {25'd0, sel};
  endtask

  task automatic cpu_write(input logic [27:0] a, input logic [27:0] d);
    drive_idle();
    bus.selEQ = 1; bus.read = 0; bus.aq = a; bus.wq = d;
  endtask

  task automatic test_reset;
    drive_idle();
    bus.RXheaderCountNonzero = 0;
    reset = 1; step(); step(); reset = 0;
    cpu_read(3'd1);
    #1;
    n_tests++;
    if (bus.rqEQ !== 32'h4) begin
      n_fail++; $display("FAIL reset_status: got %h expected %h", bus.rqEQ, 32'h4);
    end
    n_tests++;
    if ({bus.RXdmaEmpty, bus.TXdmaEmpty, bus.headerRead} !== 3'b110) begin
      n_fail++; $display("FAIL reset_outs: got %b expected 110",
                         {bus.RXdmaEmpty, bus.TXdmaEmpty, bus.headerRead});
    end
    n_tests++;
    if ({bus.done, bus.wrq, bus.rwq} !== 3'b110) begin
      n_fail++; $display("FAIL read_handshake: got %b expected 110", {bus.done, bus.wrq, bus.rwq});
    end
    step();
  endtask

  task automatic test_rx_almost_full;
    bus.RXheaderCountNonzero = 1;
    for (int i = 0; i <= 48; i++) begin
      cpu_read(3'd1);
      #1;
      n_tests++;
      if (bus.rqEQ[0] !== 1'(i < 48)) begin
        n_fail++; $display("FAIL hdr_avail[%0d]: got %b expected %b", i, bus.rqEQ[0], (i < 48));
      end
      step();
      if (i < 48) begin
        cpu_write({26'($urandom), 2'b01}, 28'($urandom));
        step();
        n_tests++;
        if (bus.headerRead !== m_hdr) begin
          n_fail++; $display("FAIL header_read[%0d]: got %b expected %b", i, bus.headerRead, m_hdr);
        end
      end
    end
    cpu_read(3'd2);
    #1;
    n_tests++;
    if (bus.rqEQ !== 32'd48) begin
      n_fail++; $display("FAIL rx_occ: got %h expected %h", bus.rqEQ, 32'd48);
    end
    step();
    for (int i = 0; i < 48; i++) begin
      drive_idle();
      bus.readRXdmaAddr = 1;
      #1;
      n_tests++;
      if (bus.RXdmaEmpty !== 1'b0 || bus.RXdmaAddr !== m_rxa[0]) begin
        n_fail++; $display("FAIL rx_drain[%0d]: got %h expected %h", i, bus.RXdmaAddr, m_rxa[0]);
      end
      step();
    end
    drive_idle();
    #1;
    n_tests++;
    if (bus.RXdmaEmpty !== 1'b1) begin
      n_fail++; $display("FAIL rx_empty_after_drain: got %b expected 1", bus.RXdmaEmpty);
    end
    bus.RXheaderCountNonzero = 0;
  endtask

  task automatic test_tx_overflow;
    for (int i = 0; i < 65; i++) begin
      cpu_write({27'($urandom), 1'b0}, 28'hA000000 + 28'(i));
      step();
    end
    cpu_read(3'd1);
    #1;
    n_tests++;
    if (bus.rqEQ[3] !== 1'b1 || bus.rqEQ !== exp_rq(3'd1, 1'b0)) begin
      n_fail++; $display("FAIL tx_oflow_status: got %h expected %h", bus.rqEQ, exp_rq(3'd1, 1'b0));
    end
    step();
    cpu_read(3'd2);
    #1;
    n_tests++;
    if (bus.rqEQ !== 32'h0040_0000) begin
      n_fail++; $display("FAIL tx_occ_full: got %h expected %h", bus.rqEQ, 32'h0040_0000);
    end
    step();
    for (int i = 0; i < 64; i++) begin
      drive_idle();
      bus.readTXdmaAddr = 1; bus.readTXdmaLength = 1;
      #1;
      n_tests++;
      if (bus.TXdmaAddr !== 28'hA000000 + 28'(i) || bus.TXdmaLength !== m_txl[0]) begin
        n_fail++; $display("FAIL tx_order[%0d]: got %h/%h expected %h/%h", i, bus.TXdmaAddr,
                           bus.TXdmaLength, 28'hA000000 + 28'(i), m_txl[0]);
      end
      step();
    end
    drive_idle();
    #1;
    n_tests++;
    if (bus.TXdmaEmpty !== 1'b1) begin
      n_fail++; $display("FAIL tx_empty_after_drain: got %b expected 1", bus.TXdmaEmpty);
    end
  endtask

  task automatic test_completion;
    cpu_write(28'h3, 28'd0);
    step();
    cpu_read(3'd0);
    #1;
    n_tests++;
    if (bus.rqEQ !== 32'd0) begin
      n_fail++; $display("FAIL cmpl_empty_read: got %h expected 0", bus.rqEQ);
    end
    step();
    cpu_read(3'd1);
    #1;
    n_tests++;
    if (bus.rqEQ[4] !== 1'b0 || bus.rqEQ[2] !== 1'b1) begin
      n_fail++; $display("FAIL cmpl_no_uflow: got %h expected uflow=0 cmplEmpty=1", bus.rqEQ);
    end
    step();
    drive_idle();
    bus.writeFrameLength = 1; bus.RXframeLength = 13'h1C40;
    step();
    cpu_read(3'd0);
    #1;
    n_tests++;
    if (bus.rqEQ !== 32'h1C40) begin
      n_fail++; $display("FAIL cmpl_read: got %h expected %h", bus.rqEQ, 32'h1C40);
    end
    step();
    cpu_read(3'd1);
    #1;
    n_tests++;
    if (bus.rqEQ[2] !== 1'b1) begin
      n_fail++; $display("FAIL cmpl_empty_after_pop: got %b expected 1", bus.rqEQ[2]);
    end
    step();
  endtask

  task automatic test_flags_full;
    drive_idle();
    bus.readTXdmaAddr = 1;
    step();
    cpu_read(3'd1);
    #1;
    n_tests++;
    if (bus.rqEQ[4] !== 1'b1) begin
      n_fail++; $display("FAIL uflow_set: got %b expected 1", bus.rqEQ[4]);
    end
    step();
    cpu_write(28'h3, 28'd0);
    step();
    cpu_read(3'd1);
    #1;
    n_tests++;
    if (bus.rqEQ[4:3] !== 2'b00) begin
      n_fail++; $display("FAIL flags_clear: got %b expected 00", bus.rqEQ[4:3]);
    end
    step();
    for (int i = 0; i < 64; i++) begin
      cpu_write({27'($urandom), 1'b0}, 28'($urandom));
      step();
    end
    cpu_write({27'($urandom), 1'b0}, 28'h5A5A5A5);
    bus.readTXdmaAddr = 1; bus.readTXdmaLength = 1;
    step();
    cpu_read(3'd2);
    #1;
    n_tests++;
    if (bus.rqEQ[22:16] !== 7'd64) begin
      n_fail++; $display("FAIL full_push_pop_count: got %0d expected 64", bus.rqEQ[22:16]);
    end
    step();
    cpu_read(3'd1);
    #1;
    n_tests++;
    if (bus.rqEQ[3] !== 1'b0) begin
      n_fail++; $display("FAIL full_push_pop_no_oflow: got %b expected 0", bus.rqEQ[3]);
    end
    step();
    for (int i = 0; i < 64; i++) begin
      drive_idle();
      bus.readTXdmaAddr = 1; bus.readTXdmaLength = 1;
      #1;
      n_tests++;
      if (bus.TXdmaAddr !== m_txa[0] || bus.TXdmaLength !== m_txl[0]) begin
        n_fail++; $display("FAIL full_drain[%0d]: got %h/%h expected %h/%h", i, bus.TXdmaAddr,
                           bus.TXdmaLength, m_txa[0], m_txl[0]);
      end
      step();
    end
  endtask

  task automatic test_stats_reset;
    logic [31:0] exp_good, exp_bad;
    exp_good = StatsEn ? 32'd3 : 32'd0;
    exp_bad  = StatsEn ? 32'd2 : 32'd0;
    for (int i = 0; i < 5; i++) begin
      drive_idle();
      bus.writeFrameLength = 1;
      bus.RXframeLength = {11'($urandom), (i < 3) ? 2'b10 : 2'b01};
      step();
    end
    cpu_read(3'd3);
    #1;
    n_tests++;
    if (bus.rqEQ !== exp_good) begin
      n_fail++; $display("FAIL stats_good: got %0d expected %0d", bus.rqEQ, exp_good);
    end
    step();
    cpu_read(3'd4);
    #1;
    n_tests++;
    if (bus.rqEQ !== exp_bad) begin
      n_fail++; $display("FAIL stats_bad: got %0d expected %0d", bus.rqEQ, exp_bad);
    end
    step();
    for (int i = 0; i < 6; i++) begin
      cpu_write({26'($urandom), 1'b0, i[0]}, 28'($urandom));
      bus.writeFrameLength = 1; bus.RXframeLength = 13'h3;
      reset = (i == 5);
      step();
    end
    reset = 0;
    cpu_read(3'd2);
    #1;
    n_tests++;
    if (bus.rqEQ !== 32'd0 || bus.RXdmaEmpty !== 1'b1 || bus.TXdmaEmpty !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_burst_occ: got %h rxE=%b txE=%b expected 0/1/1",
                         bus.rqEQ, bus.RXdmaEmpty, bus.TXdmaEmpty);
    end
    step();
    cpu_read(3'd1);
    #1;
    n_tests++;
    if (bus.rqEQ !== 32'h4 || bus.headerRead !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_burst_status: got %h hdr=%b expected 4/0",
                         bus.rqEQ, bus.headerRead);
    end
    step();
    cpu_read(3'd3);
    #1;
    n_tests++;
    if (bus.rqEQ !== 32'd0) begin
      n_fail++; $display("FAIL reset_mid_burst_stats: got %h expected 0", bus.rqEQ);
    end
    step();
  endtask

  task automatic test_random;
    drive_idle();
    reset = 1; step(); reset = 0;
    for (int c = 0; c < 3000; c++) begin
      int unsigned pop_pct;
      pop_pct = ((c / 400) % 2 == 1) ? 45 : 8;
      drive_idle();
      bus.RXheaderCountNonzero = 1'($urandom);
      if ($urandom_range(0, 99) < 60) begin
        bus.selEQ = 1; bus.read = 1'($urandom);
        bus.aq = 28'($urandom); bus.wq = 28'($urandom);
        if (!bus.read && bus.aq[4:3] == 2'b11 && $urandom_range(0, 3) != 0) bus.aq[4] = 1'b0;
      end
      bus.readRXdmaAddr   = ($urandom_range(0, 99) < pop_pct);
      bus.readTXdmaAddr   = ($urandom_range(0, 99) < pop_pct);
      bus.readTXdmaLength = ($urandom_range(0, 99) < pop_pct);
      bus.writeFrameLength = ($urandom_range(0, 99) < 5);
      bus.RXframeLength = 13'($urandom);
      reset = ($urandom_range(0, 499) == 0);
      #1;
      n_tests++;
      if ({bus.done, bus.wrq, bus.rwq} !==
          {bus.selEQ, bus.selEQ & bus.read, bus.selEQ & ~bus.read}) begin
        n_fail++; $display("FAIL rnd_handshake[%0d]: got %b", c, {bus.done, bus.wrq, bus.rwq});
      end
      if (bus.selEQ && bus.read) begin
        n_tests++;
        if (bus.rqEQ !== exp_rq(bus.aq[5:3], bus.RXheaderCountNonzero)) begin
          n_fail++; $display("FAIL rnd_rq[%0d] sel=%0d: got %h expected %h", c, bus.aq[5:3],
                             bus.rqEQ, exp_rq(bus.aq[5:3], bus.RXheaderCountNonzero));
        end
      end
      n_tests++;
      if ({bus.RXdmaEmpty, bus.TXdmaEmpty, bus.headerRead} !==
          {(m_rxa.size() == 0), (m_txa.size() == 0), m_hdr}) begin
        n_fail++; $display("FAIL rnd_flags[%0d]: got %b expected %b", c,
                           {bus.RXdmaEmpty, bus.TXdmaEmpty, bus.headerRead},
                           {(m_rxa.size() == 0), (m_txa.size() == 0), m_hdr});
      end
      if (m_txa.size() > 0) begin
        n_tests++;
        if (bus.TXdmaAddr !== m_txa[0]) begin
          n_fail++; $display("FAIL rnd_tx_head[%0d]: got %h expected %h", c, bus.TXdmaAddr, m_txa[0]);
        end
      end
      if (m_txl.size() > 0) begin
        n_tests++;
        if (bus.TXdmaLength !== m_txl[0]) begin
          n_fail++; $display("FAIL rnd_txlen_head[%0d]: got %h expected %h", c, bus.TXdmaLength,
                             m_txl[0]);
        end
      end
      if (m_rxa.size() > 0) begin
        n_tests++;
        if (bus.RXdmaAddr !== m_rxa[0]) begin
          n_fail++; $display("FAIL rnd_rx_head[%0d]: got %h expected %h", c, bus.RXdmaAddr, m_rxa[0]);
        end
      end
      step();
    end
    reset = 0;
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_rx_almost_full();
    test_tx_overflow();
    test_completion();
    test_flags_full();
    test_stats_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
